route_lane_dispatch: RTL and testbench

//  Command-driven dispatcher feeding the 8 systolic lanes of the data route.
//  A command (3-bit lane select + burst length) opens a burst; the following

---
 rtl/route_lane_dispatch.sv | 145 ++++++++++++++
 tb/tb_route_lane_dispatch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_lane_dispatch.sv
// Command-driven burst dispatcher: routes data beats through a one-beat output register to one of 8 lanes.
// Optional broadcast mode (all lanes take each beat together) is compiled in with `define ROUTE_BCAST_EN.
module route_lane_dispatch #(
    parameter int DW = 32,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_sel,
    input  logic [LW-1:0] cmd_len,
    input  logic          cmd_bcast,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic [7:0]    out_valid,
    input  logic [7:0]    out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mask_q, mask_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [7:0]    out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic          ov;
    logic          ofire;
    logic          cmd_fire;
    logic          in_fire;
    logic [2:0]    lane;
    logic [7:0]    lane_onehot;

    // Lane index is the bit-reversed select field.
    assign lane        = {cmd_sel[0], cmd_sel[1], cmd_sel[2]};
    assign lane_onehot = 8'b0000_0001 << lane;
    assign ov          = |out_valid_q;

`ifdef ROUTE_BCAST_EN
    logic bcast_q, bcast_d;

    // A broadcast beat is delivered only when every lane is ready in the same cycle.
    always_comb begin
        if (bcast_q) begin
            ofire = ov & (&(out_ready | ~out_valid_q));
        end else begin
            ofire = |(out_valid_q & out_ready);
        end
    end
`else
    logic unused_cmd_bcast;
    assign unused_cmd_bcast = cmd_bcast;
    assign ofire            = |(out_valid_q & out_ready);
`endif

    assign cmd_ready = (state_q == IDLE);
    assign in_ready  = (state_q == ROUTE) & (~ov | ofire);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DRAIN) & ofire;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef ROUTE_BCAST_EN
        bcast_d     = bcast_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    cnt_d   = cmd_len;
                    state_d = ROUTE;
`ifdef ROUTE_BCAST_EN
                    bcast_d = cmd_bcast;
                    mask_d  = cmd_bcast ? 8'hFF : lane_onehot;
`else
                    mask_d  = lane_onehot;
`endif
                end
            end
            ROUTE: begin
                // cnt holds beats remaining minus one, so len=2^LW-1 never wraps.
                if (in_fire) begin
                    if (cnt_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q - LW'(1);
                    end
                end
            end
            DRAIN: begin
                if (ofire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A reload in the same cycle as a fire keeps the register full.
        if (in_fire) begin
            out_valid_d = mask_q;
            out_data_d  = in_data;
        end else if (ofire) begin
            out_valid_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= 8'h00;
            cnt_q       <= '0;
            out_valid_q <= 8'h00;
            out_data_q  <= '0;
`ifdef ROUTE_BCAST_EN
            bcast_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef ROUTE_BCAST_EN
            bcast_q     <= bcast_d;
`endif
        end
    end

endmodule

// File: tb/tb_route_lane_dispatch.sv
// Bench for route_lane_dispatch: table of bursts checked through a beat scoreboard, plus reset sequences.
`timescale 1ns/1ps
module tb_route_lane_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        cmd_bcast;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic        busy;
    logic        done;

    route_lane_dispatch #(.DW(32), .LW(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_len(cmd_len), .cmd_bcast(cmd_bcast),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mask;
        logic [31:0] data;
        logic        last;
        logic        bc;
    } sb_t;

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  len;
        logic        bcast;
        logic [31:0] base;
        logic [7:0]  stall_mask;
        int          stall_cycles;
        logic [7:0]  exp_mask;
        logic        hold_next;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];
    sb_t  sbq[$];

    int         checks = 0;
    int         failures = 0;
    logic [7:0] cur_mask = 8'h00;
    logic       cur_last = 1'b0;
    logic       cur_bc = 1'b0;
    logic       in_burst = 1'b0;
    int         stall_left = 0;
    logic [7:0] stall_mask = 8'hFF;
    logic       cmd_hs = 1'b0;
    logic       in_hs = 1'b0;
    logic       done_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: set out_ready, sample at negedge, score outputs, record handshakes, return #1 after posedge.
    task automatic cycle();
        sb_t  e;
        logic fire;
        out_ready = (stall_left > 0) ? stall_mask : 8'hFF;
        if (stall_left > 0) stall_left--;
        @(negedge clk);
        cmd_hs    = 1'b0;
        in_hs     = 1'b0;
        done_seen = 1'b0;
        if (!rst) begin
            chk("sb_occupancy", 64'(sbq.size()), (out_valid != 8'h00) ? 64'd1 : 64'd0);
            chk("busy", 64'(busy), 64'(in_burst));
            chk("cmd_ready", 64'(cmd_ready), 64'(!in_burst));
            if (!in_burst) chk("in_ready_idle", 64'(in_ready), 64'd0);
            if (sbq.size() > 0) begin
                e = sbq[0];
                chk("out_valid", 64'(out_valid), 64'(e.mask));
                chk("out_data", 64'(out_data), 64'(e.data));
                fire = e.bc ? (&(out_ready | ~out_valid)) : (|(out_valid & out_ready));
                chk("done", 64'(done), 64'(fire & e.last));
                if (!fire) chk("in_ready_held", 64'(in_ready), 64'd0);
                if (fire) begin
                    sbq.delete(0);
                    if (e.last) begin
                        done_seen = 1'b1;
                        in_burst  = 1'b0;
                    end
                end
            end else begin
                chk("done_idle", 64'(done), 64'd0);
            end
            if (cmd_valid && cmd_ready) begin
                cmd_hs   = 1'b1;
                in_burst = 1'b1;
            end
            if (in_valid && in_ready) begin
                in_hs = 1'b1;
                sbq.push_back('{cur_mask, in_data, cur_last, cur_bc});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input vec_t v, input logic hold, input vec_t nxt, input logic imm);
        int guard;
        int idx;
        int beat_cycles;
        cur_mask = v.exp_mask;
`ifdef ROUTE_BCAST_EN
        cur_bc = v.bcast;
`else
        cur_bc = 1'b0;
`endif
        cmd_valid = 1'b1;
        cmd_sel   = v.sel;
        cmd_len   = v.len;
        cmd_bcast = v.bcast;
        // First beat is already offered while idle; it must wait for the command.
        in_valid  = 1'b1;
        in_data   = v.base;
        cur_last  = (v.len == 8'd0);
        guard = 0;
        do begin
            cycle();
            guard++;
        end while (!cmd_hs && guard < 50);
        chk("cmd_accept", 64'(cmd_hs), 64'd1);
        if (imm) chk("held_cmd_immediate", 64'(guard), 64'd1);
        if (hold) begin
            cmd_valid = 1'b1;
            cmd_sel   = nxt.sel;
            cmd_len   = nxt.len;
            cmd_bcast = nxt.bcast;
        end else begin
            cmd_valid = 1'b0;
        end
        stall_mask  = v.stall_mask;
        stall_left  = v.stall_cycles;
        idx         = 0;
        beat_cycles = 0;
        while (idx <= int'(v.len) && beat_cycles < 2000) begin
            in_valid = 1'b1;
            in_data  = v.base + 32'(idx);
            cur_last = (idx == int'(v.len));
            cycle();
            beat_cycles++;
            if (in_hs) idx++;
        end
        in_valid = 1'b0;
        chk("beats_sent", 64'(idx), 64'(int'(v.len) + 1));
        if (v.stall_cycles == 0) chk("throughput", 64'(beat_cycles), 64'(int'(v.len) + 1));
        guard = 0;
        while (!done_seen && guard < 50) begin
            cycle();
            guard++;
        end
        chk("done_seen", 64'(done_seen), 64'd1);
    endtask

    vec_t rv;
    vec_t dummy;
    int   sent;
    int   g;

    initial begin
        vecs[0] = '{3'b001, 8'd3,   1'b0, 32'h0000_00A0, 8'hFF, 0, 8'h10, 1'b0};
        vecs[1] = '{3'b110, 8'd1,   1'b0, 32'h0000_00B0, 8'hF7, 5, 8'h08, 1'b1};
        vecs[2] = '{3'b111, 8'd2,   1'b0, 32'h0000_00C0, 8'hFF, 0, 8'h80, 1'b0};
        vecs[3] = '{3'b000, 8'd0,   1'b0, 32'h0000_00D0, 8'hFF, 0, 8'h01, 1'b0};
        vecs[4] = '{3'b010, 8'd4,   1'b0, 32'h0000_0E00, 8'hFF, 0, 8'h04, 1'b0};
        vecs[5] = '{3'b011, 8'd255, 1'b0, 32'h0000_1000, 8'hFF, 0, 8'h40, 1'b0};
        vecs[6] = '{3'b100, 8'd2,   1'b0, 32'h0000_2000, 8'hFF, 0, 8'h02, 1'b0};
        vecs[7] = '{3'b101, 8'd2,   1'b0, 32'h0000_3000, 8'h00, 3, 8'h20, 1'b0};
`ifdef ROUTE_BCAST_EN
        vecs[8] = '{3'b011, 8'd0,   1'b1, 32'h0000_4000, 8'h7F, 3, 8'hFF, 1'b0};
`else
        vecs[8] = '{3'b011, 8'd0,   1'b1, 32'h0000_4000, 8'h7F, 3, 8'h40, 1'b0};
`endif

        // Reset with every input driven high.
        rst = 1'b1; cmd_valid = 1'b1; cmd_sel = 3'b111; cmd_len = 8'hFF; cmd_bcast = 1'b1;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 8'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'h00);
        chk("reset_out_data", 64'(out_data), 64'h0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        cmd_valid = 1'b0; in_valid = 1'b0; cmd_bcast = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            burst(vecs[i], vecs[i].hold_next, vecs[(i + 1) % NV], (i > 0) && vecs[i - 1].hold_next);
        end

        // Reset after 2 of 5 beats: burst abandoned, no done, then a single-beat burst to lane 0.
        cur_mask = 8'h04; cur_bc = 1'b0; cur_last = 1'b0;
        cmd_valid = 1'b1; cmd_sel = 3'b010; cmd_len = 8'd4; cmd_bcast = 1'b0;
        g = 0;
        do begin
            cycle();
            g++;
        end while (!cmd_hs && g < 50);
        chk("midrst_cmd_accept", 64'(cmd_hs), 64'd1);
        cmd_valid = 1'b0;
        sent = 0;
        g = 0;
        while (sent < 2 && g < 20) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_5000 + 32'(sent);
            cycle();
            g++;
            if (in_hs) sent++;
        end
        chk("midrst_beats", 64'(sent), 64'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_no_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        in_burst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'h00);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        rv = '{3'b000, 8'd0, 1'b0, 32'h0000_6000, 8'hFF, 0, 8'h01, 1'b0};
        dummy = rv;
        burst(rv, 1'b0, dummy, 1'b0);

        repeat (3) cycle();
        chk("final_sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete, time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
